// File: rtl/irq_aggregator.sv
// irq_aggregator: per-source rising-edge capture into sticky pending bits,
// software mask, single level irq, Avalon-MM slave (PENDING/MASK/STATUS/ID).
// Optional macro IRQ_AGG_SYNC_EN: 2-flop synchronizer per source instead of
// a single sampling flop.

// One source lane: sample, edge detect, sticky pending with set-beats-clear.
module irq_agg_src (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clr,
  output logic pending
);
  logic s, prev, rise;

`ifdef IRQ_AGG_SYNC_EN
  logic meta;
  // Two-flop synchronizer; s is the second stage
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= irq_in;
      s    <= meta;
    end
`else
  // Single sampling flop for sources already synchronous to clk
  always_ff @(posedge clk or posedge reset)
    if (reset) s <= 1'b0;
    else       s <= irq_in;
`endif

  assign rise = s & ~prev;

  // Edge history and sticky pending; a rise wins over a same-cycle clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= s;
      pending <= rise | (pending & ~clr);
    end
endmodule

module irq_aggregator #(
  parameter int N_SRC = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);
  localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_STAT = 2'd2, A_ID = 2'd3;

  logic [N_SRC-1:0] pending, mask, status, ack_vec, clr;
  logic [4:0]       id_idx;
  logic             id_valid;
  logic [31:0]      id_word, rd_mux;
  logic             wr_pend, wr_mask, wr_ack;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata[31:N_SRC];

  assign wr_pend = avs_write && (avs_address == A_PEND);
  assign wr_mask = avs_write && (avs_address == A_MASK);
  assign wr_ack  = avs_write && (avs_address == A_ID);

  assign status   = pending & mask;
  assign id_valid = |status;
  assign irq      = id_valid;

  // Isolate the lowest set STATUS bit; zero when nothing is pending
  assign ack_vec = status & (~status + {{(N_SRC-1){1'b0}}, 1'b1});
  assign clr     = (wr_pend ? avs_writedata[N_SRC-1:0] : '0) | (wr_ack ? ack_vec : '0);

  // Lowest set index in STATUS (priority goes to bit 0)
  always_comb begin
    id_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (status[i]) id_idx = 5'(i);
  end

  assign id_word = id_valid ? {1'b1, 26'b0, id_idx} : 32'b0;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      irq_agg_src u_src (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in[g]),
        .clr     (clr[g]),
        .pending (pending[g])
      );
    end
  endgenerate

  // Software mask register
  always_ff @(posedge clk or posedge reset)
    if (reset)        mask <= '0;
    else if (wr_mask) mask <= avs_writedata[N_SRC-1:0];

  // Read mux over pre-write state
  always_comb begin
    rd_mux = 32'b0;
    case (avs_address)
      A_PEND:  rd_mux = 32'(pending);
      A_MASK:  rd_mux = 32'(mask);
      A_STAT:  rd_mux = 32'(status);
      default: rd_mux = id_word;
    endcase
  end

  // Read data register: latency 1, held until the next read
  always_ff @(posedge clk or posedge reset)
    if (reset)         avs_readdata <= 32'b0;
    else if (avs_read) avs_readdata <= rd_mux;
endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: directed scenarios followed by
// random traffic, all compared against a behavioural model.
module tb_irq_aggregator;
  localparam int N = 14;
`ifdef IRQ_AGG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic [1:0]    avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  logic [N-1:0] m_pend, m_mask;
  logic [31:0]  m_rd;
  logic [N-1:0] h [0:3];  // h[j] = irq_in sampled j edges ago

  irq_aggregator #(.N_SRC(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_in        (irq_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [N-1:0] st;
    int idx;
    st = m_pend & m_mask;
    idx = first_set(st);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(st);
      default: return (idx < 0) ? 32'h0 : (32'h8000_0000 | 32'(idx));
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_rd = '0;
    for (int j = 0; j < 4; j++) h[j] = '0;
  endtask

  // One clock edge of the model, using the inputs present before the edge
  task automatic model_step();
    logic [N-1:0] rise, clr, st;
    int idx;
    if (reset) begin
      model_reset();
      return;
    end
    if (avs_read) m_rd = model_read(avs_address);
    for (int j = 3; j > 0; j--) h[j] = h[j-1];
    h[0] = irq_in;
    rise = h[LAT] & ~h[LAT+1];
    clr = '0;
    st = m_pend & m_mask;
    if (avs_write) begin
      case (avs_address)
        2'd0: clr = avs_writedata[N-1:0];
        2'd3: begin
          idx = first_set(st);
          if (idx >= 0) clr = N'(1) << idx;
        end
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | rise;
    if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[N-1:0];
  endtask

  // Advance one clock, update model, check outputs, return at negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", 32'(irq), 32'(|(m_pend & m_mask)));
    chk("rdata", avs_readdata, m_rd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    avs_read = r; avs_write = w; avs_address = a; avs_writedata = d;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    irq_in = irq_in | bits;
    tick();
    irq_in = irq_in & ~bits;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; avs_address = '0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0;
    model_reset();
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_rdata", avs_readdata, 32'h0);

    // Single pulse on source 2
    bus(0, 1, 2'd1, 32'h3FFF);
    pulse(14'h0004);
    idle(LAT + 1);
    bus(1, 0, 2'd0, 0);
    chk("pend_2", avs_readdata, 32'h0000_0004);
    bus(1, 0, 2'd3, 0);
    chk("id_2", avs_readdata, 32'h8000_0002);

    // Acknowledge by ID: sources 5 and 9
    bus(0, 1, 2'd0, 32'h3FFF);
    pulse(14'h0220);
    idle(LAT + 1);
    bus(0, 1, 2'd3, 32'hFFFF_FFFF);
    bus(1, 0, 2'd3, 0);
    chk("id_9", avs_readdata, 32'h8000_0009);
    bus(0, 1, 2'd3, 0);
    bus(1, 0, 2'd3, 0);
    chk("id_none", avs_readdata, 32'h0);
    chk("irq_acked", 32'(irq), 32'h0);

    // Masked source still latches
    bus(0, 1, 2'd1, 0);
    pulse(14'h0001);
    idle(LAT + 1);
    chk("irq_masked", 32'(irq), 32'h0);
    bus(1, 0, 2'd0, 0);
    chk("pend_masked", avs_readdata, 32'h1);
    bus(0, 1, 2'd1, 32'h1);
    chk("irq_unmask", 32'(irq), 32'h1);
    bus(0, 1, 2'd0, 32'h1);

    // W1C of bit 3 on the same edge that its rise lands
    bus(0, 1, 2'd1, 32'h3FFF);
    irq_in[3] = 1'b1;
    idle(LAT);
    bus(0, 1, 2'd0, 32'h8);
    irq_in[3] = 1'b0;
    bus(1, 0, 2'd0, 0);
    chk("set_beats_clr", avs_readdata & 32'h8, 32'h8);
    bus(0, 1, 2'd0, 32'h8);

    // Held level on source 7 sets once
    irq_in[7] = 1'b1;
    idle(5);
    bus(0, 1, 2'd0, 32'h80);
    idle(14);
    bus(1, 0, 2'd0, 0);
    chk("hold_no_reset", avs_readdata & 32'h80, 32'h0);
    irq_in[7] = 1'b0;
    idle(2);
    pulse(14'h0080);
    idle(LAT + 1);
    bus(1, 0, 2'd0, 0);
    chk("hold_rearm", avs_readdata & 32'h80, 32'h80);

    // Asynchronous reset mid-operation, source 1 held through release
    pulse(14'h3FFF);
    idle(LAT + 1);
    bus(1, 0, 2'd0, 0);
    chk("pend_all", avs_readdata, 32'h3FFF);
    irq_in[1] = 1'b1;
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_rdata", avs_readdata, 32'h0);
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    idle(LAT + 3);
    irq_in[1] = 1'b0;
    bus(1, 0, 2'd0, 0);
    chk("rst_rise", avs_readdata, 32'h2);
    bus(1, 0, 2'd1, 0);
    chk("rst_mask", avs_readdata, 32'h0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
      avs_read = ($urandom_range(2) == 0);
      avs_write = ($urandom_range(3) == 0);
      avs_address = 2'($urandom_range(3));
      avs_writedata = $urandom;
      tick();
    end
    avs_read = 1'b0; avs_write = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Collects the per-source interrupt pulses from the button/switch front end (4 button lines, 10 switch-change lines) into sticky pending bits, applies a software mask, and raises a single level interrupt to the processor. Software services it over an Avalon-MM slave: read the pending/status/ID registers, then clear by write-1-to-clear or by acknowledging the reported ID. It sits between the input front end and the HPS/Nios interrupt input.

## Interface
- N_SRC, 14, number of interrupt sources (1..31); bits [3:0] are buttons and [13:4] are switches in the default build.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- irq_in  in  N_SRC  source request lines, active-high, any pulse width ≥ 1 clk.
- avs_address  in  2  word address: 0 PENDING, 1 MASK, 2 STATUS, 3 ID.
- avs_read  in  1  read strobe, one cycle per transfer.
- avs_write  in  1  write strobe, one cycle per transfer.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency 1.
- irq  out  1  level interrupt to processor.

## Operation
- Rising-edge detect per source: `rise[i] = s[i] & ~prev[i]`, where s is the sampled input (see Configuration) and prev is s delayed one clk. Each rise sets `pending[i]`; pending is sticky until software clears it.
- A level held high produces exactly one set; re-arming requires a low of at least 1 sampled cycle.
- `STATUS = pending & mask`. `irq = |STATUS`, driven combinationally from registered state only, so it is glitch-free per clk.
- ID register: bit 31 = valid (STATUS != 0); bits [4:0] = lowest set index in STATUS; all other bits 0. If valid = 0, it reads all-zero.
- Writes:
  - Addr 0: W1C on pending[N_SRC-1:0].
  - Addr 1: mask <= writedata[N_SRC-1:0].
  - Addr 2: ignored.
  - Addr 3: acknowledge. Clears pending[ID index] if valid; ignored otherwise. writedata is ignored.
- Set beats clear: if rise[i] and a clear of bit i occur in the same cycle, pending[i] ends at 1.
- Masking does not discard events. A masked source still latches pending, and irq asserts as soon as the mask bit is set.
- Unused upper bits read 0; writes to them are ignored.
- Read and write in the same cycle: the write takes effect, and the read returns the pre-write value.
- Reset values: pending 0, mask 0, all sync/prev flops 0, avs_readdata 0, irq 0.
- Reset mid-operation: clears all state asynchronously. A source still high when reset releases is seen as a rising edge and sets pending once.

## Timing
- Read: avs_read sampled at edge k; avs_readdata is valid after edge k and held until the next read. There is no waitrequest.
- Write: takes effect at the edge that samples avs_write. irq reflects the new state after that same edge.
- Event latency with sync (macro defined): irq_in high before edge k gives s at edge k+1, pending at edge k+2, irq after edge k+2.
- Event latency without sync: s at edge k, pending at edge k+1, irq after edge k+1.
- Back-to-back reads and writes are permitted every cycle.

## Configuration
- IRQ_AGG_SYNC_EN:
  - Defined: irq_in passes through a 2-flop synchronizer per bit before edge detection, so s is the second flop.
  - Undefined: a single sampling flop, for sources already synchronous to clk. The latency is one cycle shorter.
  - Register map and software behaviour are identical in both builds.

## Test plan
- Reset, write MASK=0x3FFF, pulse irq_in[2] for 1 clk -> pending=0x0004 and irq=1 at the documented latency; ID reads 0x80000002.
- Sources 5 and 9 pending and unmasked; write ID twice -> first write clears bit 5 (ID then reads 0x80000009), second clears bit 9; irq=0; ID reads 0.
- MASK=0, pulse irq_in[0] -> irq stays 0 and PENDING=0x0001; write MASK=0x0001 -> irq=1 after that edge.
- W1C of bit 3 in the same cycle as a new rise on irq_in[3] -> pending[3] remains 1.
- Hold irq_in[7] high for 20 clks, W1C bit 7 mid-hold -> bit 7 is not re-set until irq_in[7] goes low and rises again.
- Assert reset while pending=0x3FFF and irq=1 -> pending, mask, readdata and irq are all 0 immediately. With irq_in[1] held high through reset release -> pending=0x0002 once.
